// File: rtl/pool2x2_if.sv
// Pixel-stream bundle for the 2x2 pooling stage: input pixels with frame/line
// markers, pooled output with regenerated markers. POOL2X2_AVG_EN adds avg_mode.
interface pool2x2_if #(
    parameter int DATA_W = 16
);
    logic                     ena;
    logic                     frame_start_in;
    logic                     line_start_in;
    logic                     frame_end_in;
    logic signed [DATA_W-1:0] sig_in;
    logic signed [DATA_W-1:0] pool_out;
    logic                     valid;
    logic                     frame_start_out;
    logic                     line_start_out;
    logic                     frame_end_out;
`ifdef POOL2X2_AVG_EN
    logic                     avg_mode;

    modport master (
        output ena, frame_start_in, line_start_in, frame_end_in, sig_in, avg_mode,
        input  pool_out, valid, frame_start_out, line_start_out, frame_end_out
    );
    modport slave (
        input  ena, frame_start_in, line_start_in, frame_end_in, sig_in, avg_mode,
        output pool_out, valid, frame_start_out, line_start_out, frame_end_out
    );
`else
    modport master (
        output ena, frame_start_in, line_start_in, frame_end_in, sig_in,
        input  pool_out, valid, frame_start_out, line_start_out, frame_end_out
    );
    modport slave (
        input  ena, frame_start_in, line_start_in, frame_end_in, sig_in,
        output pool_out, valid, frame_start_out, line_start_out, frame_end_out
    );
`endif
endinterface

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 pooling (signed max; floor average when built with
// POOL2X2_AVG_EN and avg_mode=1). The line store keeps horizontal pair results.
module pool2x2_stream #(
    parameter int DATA_W   = 16,
    parameter int MAX_COLS = 32,
    parameter int BUF_AW   = 4
) (
    input logic       clk,
    input logic       rst,
    pool2x2_if.slave  px
);
    localparam int CW = $clog2(MAX_COLS + 1);
    localparam logic [CW-1:0] MAX_COL_C = CW'(MAX_COLS);
`ifdef POOL2X2_AVG_EN
    localparam int BW = DATA_W + 1;
    localparam int HW = DATA_W + 1;
    localparam int SW = DATA_W + 2;
`else
    localparam int BW = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2
    } state_t;

    state_t                   state_r;
    logic [CW-1:0]            col_r;
    logic                     row_odd_r;
    logic                     first_pend_r;
    logic signed [DATA_W-1:0] h_reg_r;
    logic signed [BW-1:0]     line_buf_r [2**BUF_AW];
    logic signed [DATA_W-1:0] pool_out_r;
    logic                     valid_r;
    logic                     fso_r;
    logic                     lso_r;
    logic                     feo_r;

    logic [CW-1:0]            pix_col_s;
    logic                     pix_odd_s;
    logic                     accept_s;
    logic [BUF_AW-1:0]        idx_s;
    logic signed [BW-1:0]     buf_rd_s;
    logic signed [DATA_W-1:0] hmax_s;
    logic signed [BW-1:0]     hres_s;
    logic signed [DATA_W-1:0] pooled_s;
`ifdef POOL2X2_AVG_EN
    logic                     avg_mode_r;
    logic                     avg_eff_s;
    logic signed [SW-1:0]     sum4_s;
`endif

    // Column/row position of the current pixel and the pooled datapath result.
    always_comb begin
        pix_col_s = col_r;
        if (px.frame_start_in || px.line_start_in) begin
            pix_col_s = {CW{1'b0}};
        end else begin
            pix_col_s = col_r;
        end
        if (px.frame_start_in) begin
            pix_odd_s = 1'b0;
        end else if (px.line_start_in) begin
            pix_odd_s = ~row_odd_r;
        end else begin
            pix_odd_s = row_odd_r;
        end
        // Pixels outside a frame or beyond the line store are dropped.
        accept_s = px.ena && (px.frame_start_in || (state_r != IDLE)) && (pix_col_s < MAX_COL_C);
        idx_s    = BUF_AW'(pix_col_s >> 1);
        buf_rd_s = line_buf_r[idx_s];
        hmax_s   = (h_reg_r > px.sig_in) ? h_reg_r : px.sig_in;
`ifdef POOL2X2_AVG_EN
        if (px.frame_start_in) begin
            avg_eff_s = px.avg_mode;
        end else begin
            avg_eff_s = avg_mode_r;
        end
        sum4_s = {SW{1'b0}};
        if (avg_eff_s) begin
            hres_s   = HW'(h_reg_r) + HW'(px.sig_in);
            sum4_s   = SW'(hres_s) + SW'(buf_rd_s);
            pooled_s = DATA_W'(sum4_s >>> 2);
        end else begin
            hres_s   = BW'(hmax_s);
            pooled_s = DATA_W'((hres_s > buf_rd_s) ? hres_s : buf_rd_s);
        end
`else
        hres_s   = hmax_s;
        pooled_s = (hres_s > buf_rd_s) ? hres_s : buf_rd_s;
`endif
    end

    // Counters, row FSM, horizontal hold register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            col_r        <= {CW{1'b0}};
            row_odd_r    <= 1'b0;
            first_pend_r <= 1'b0;
            h_reg_r      <= {DATA_W{1'b0}};
            pool_out_r   <= {DATA_W{1'b0}};
            valid_r      <= 1'b0;
            fso_r        <= 1'b0;
            lso_r        <= 1'b0;
            feo_r        <= 1'b0;
`ifdef POOL2X2_AVG_EN
            avg_mode_r   <= 1'b0;
`endif
        end else begin
            valid_r <= 1'b0;
            fso_r   <= 1'b0;
            lso_r   <= 1'b0;
            feo_r   <= px.ena & px.frame_end_in;
            if (px.ena) begin
                if (px.frame_start_in || px.line_start_in) begin
                    col_r <= CW'(1);
                end else if (col_r < MAX_COL_C) begin
                    col_r <= col_r + CW'(1);
                end
                row_odd_r <= pix_odd_s;
                if (px.frame_end_in) begin
                    state_r <= IDLE;
                end else if (px.frame_start_in) begin
                    state_r <= EVEN_ROW;
                end else begin
                    case (state_r)
                        IDLE:     state_r <= IDLE;
                        EVEN_ROW: state_r <= px.line_start_in ? ODD_ROW : EVEN_ROW;
                        ODD_ROW:  state_r <= px.line_start_in ? EVEN_ROW : ODD_ROW;
                        default:  state_r <= IDLE;
                    endcase
                end
                if (px.frame_start_in) begin
                    first_pend_r <= 1'b1;
`ifdef POOL2X2_AVG_EN
                    avg_mode_r   <= px.avg_mode;
`endif
                end
                if (accept_s) begin
                    if (!pix_col_s[0]) begin
                        h_reg_r <= px.sig_in;
                    end else if (pix_odd_s) begin
                        pool_out_r   <= pooled_s;
                        valid_r      <= 1'b1;
                        lso_r        <= (pix_col_s == CW'(1));
                        fso_r        <= first_pend_r;
                        first_pend_r <= 1'b0;
                    end
                end
            end
        end
    end

    // Even-row horizontal results parked for the row below; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept_s && pix_col_s[0] && !pix_odd_s) begin
            line_buf_r[idx_s] <= hres_s;
        end
    end

    assign px.pool_out        = pool_out_r;
    assign px.valid           = valid_r;
    assign px.frame_start_out = fso_r;
    assign px.line_start_out  = lso_r;
    assign px.frame_end_out   = feo_r;
endmodule
